fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Front-end fetch stage: generates PCs, issues CORE_WIDTH-wide block requests to instruction memory,
//  and buffers returned blocks. Drives pc_addr_f/instr_blk_f into the fetch-decode pipeline buffer,
//  which captures them whenever hold_fd is low. Handles redirects (branch/jump/flush) by killing
//  in-flight requests and restarting at the target.
// PARAMETERS
//  CORE_WIDTH      2          instructions per fetch block; block = CORE_WIDTH*32 bits, PC step = CORE_WIDTH*4
//  RESET_PC        32'h0      first fetch address after reset
//  QUEUE_DEPTH     4          fetch-queue entries, power of 2, >=2
//  MAX_OUTSTANDING 2          max accepted-but-unanswered imem requests, <= QUEUE_DEPTH
// PORTS
//  clk             in   1            clock, rising edge
//  reset_n         in   1            asynchronous active-low reset
//  hold_fd         in   1            decode stall; 1 = fetch-decode buffer not capturing this cycle
//  redirect_valid  in   1            restart fetch at redirect_pc
//  redirect_pc     in   32           redirect target; bits[1:0] forced to 0 internally
//  imem_req_valid  out  1            request valid
//  imem_req_ready  in   1            imem accepts request (fires on valid&&ready)
//  imem_req_addr   out  32           block address
//  imem_resp_valid in   1            response valid; in order, latency >=1, no backpressure
//  imem_resp_data  in   CORE_WIDTH*32  instruction block, slot 0 in bits [31:0]
//  pc_addr_f       out  32           PC of head block
//  instr_blk_f     out  CORE_WIDTH*32  head block, or NOP block when empty
//  fetch_valid     out  1            head block valid (queue non-empty)
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, queue empty, outstanding=0, kill bits clear. Outputs:
//   imem_req_valid=0, imem_req_addr=RESET_PC, pc_addr_f=0, instr_blk_f={CORE_WIDTH{32'h00000013}},
//   fetch_valid=0. First request is presented on the first cycle after reset_n rises.
//  Request: imem_req_valid = !redirect_valid && (outstanding + q_count) < QUEUE_DEPTH
//   && outstanding < MAX_OUTSTANDING. imem_req_addr = fetch_pc.
//   On fire: fetch_pc += CORE_WIDTH*4 (mod 2^32, wraps silently); push in-order tag {pc, kill=0}.
//   While valid && !ready: address stays stable, except when a redirect occurs.
//  Response: pop oldest tag. If kill=1, drop the data. Otherwise push {tag.pc, imem_resp_data} into the queue.
//   Credit rule guarantees no overflow. A response with outstanding==0 is illegal (assert) and is ignored.
//  Output: combinational from queue head. Empty -> fetch_valid=0, pc_addr_f=0, NOP block.
//   Pop when fetch_valid && !hold_fd. Latency: response cycle N -> visible at pc_addr_f in cycle N+1.
//  Redirect (highest priority, single cycle):
//   - flush queue; set kill on all outstanding tags.
//   - a request firing in the same cycle is also tagged kill=1.
//   - a response arriving in the same cycle is dropped.
//   - fetch_pc <= {redirect_pc[31:2],2'b00}; imem_req_valid=0 in the redirect cycle.
//   - an un-accepted request is abandoned; the next request uses the new PC.
//   - redirect && hold_fd: flush still wins, and the outputs show NOP/fetch_valid=0 next cycle.
//  Back-to-back redirects: the last redirect wins; kill bits are sticky until the tag pops.
//  Full queue with hold_fd=1: no requests issue; everything stalls losslessly.
//  Push and pop in the same cycle: count unchanged; an empty queue is not bypassed
//   (data is always registered first).
// STRUCTURE
//  fetch_pkg:
//   - NOP_INSTR=32'h00000013
//   - fetch_entry_t struct {pc[31:0], blk[CORE_WIDTH*32-1:0]}
//   - inflight_tag_t {pc, kill}
//   - function fetch_bytes(CORE_WIDTH)
//  Sub-module fetch_queue #(DEPTH, type T):
//   - sync FIFO with push/pop/flush, count, and head output
//   - flush beats push in the same cycle
//  Tag tracker: a small in-order array of MAX_OUTSTANDING inflight_tag_t, kept inline in fetch_unit.
// TESTING
//  1 Reset, ready=1, 1-cycle resp: addrs 0x0,0x8,0x10...; pc_addr_f=0x0 two cycles after first fire; no NOPs once streaming.
//  2 hold_fd=1 for 10 cycles: queue fills to 4, imem_req_valid drops; release -> blocks 0x0..0x18 in order, none lost.
//  3 Two requests in flight (0x20,0x28), redirect to 0x103: both responses dropped; next req addr 0x100; pc_addr_f=0x100 first.
//  4 Redirect in same cycle as a response and a firing request: both dropped; fetch_valid=0 next cycle.
//  5 imem_req_ready=0 for 5 cycles: addr stable at 0x40; redirect during stall -> addr becomes target, 0x40 never consumed.
//  6 fetch_pc=0xFFFFFFF8 fire -> next addr 0x00000000; async reset mid-stream -> outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage.
//   FETCH_WIDTH    : instructions per fetch block carried by fetch_entry_t
//   NOP_INSTR      : encoding shown on instr_blk_f slots when nothing is valid
//   fetch_entry_t  : one buffered block {pc, blk}
//   inflight_tag_t : bookkeeping for one accepted imem request {pc, kill}
//   fetch_bytes()  : PC step for a block of the given width
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]               pc;
    logic [FETCH_WIDTH*32-1:0] blk;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } inflight_tag_t;

  function automatic logic [31:0] fetch_bytes(input int unsigned width);
    return 32'(width * 4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched blocks; flush beats push, head is combinational.
//   clk, reset_n : clock, async active-low reset
//   push/push_data : write one entry (ignored when full without a pop)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO this cycle
//   count        : number of valid entries
//   head         : oldest entry (undefined when count == 0)
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output T                             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((32'(count) < DEPTH) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues block requests to imem, tracks in-flight requests in order,
// buffers returned blocks and presents the oldest to the fetch-decode buffer.
//   clk, reset_n     : clock, async active-low reset
//   hold_fd          : decode stall, head is not consumed while high
//   redirect_valid/pc: restart fetch at redirect_pc (word aligned internally)
//   imem_req_*       : valid/ready request channel, block address
//   imem_resp_*      : in-order response channel, no backpressure
//   pc_addr_f, instr_blk_f, fetch_valid : head block towards decode (NOP when empty)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned CORE_WIDTH      = FETCH_WIDTH,
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold_fd,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [31:0]             imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [CORE_WIDTH*32-1:0] imem_resp_data,
  output logic [31:0]             pc_addr_f,
  output logic [CORE_WIDTH*32-1:0] instr_blk_f,
  output logic                    fetch_valid
);

  localparam int unsigned QW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic          run;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  inflight_tag_t tags   [MAX_OUTSTANDING];
  inflight_tag_t tags_n [MAX_OUTSTANDING];
  logic [IW-1:0] wr_idx;

  logic          req_fire;
  logic          resp_take;
  logic          q_push;
  logic          q_pop;
  logic [QW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  // Credit check counts both in-flight requests and buffered blocks so the queue never overflows.
  assign imem_req_valid = run && !redirect_valid
                       && ((32'(outstanding) + 32'(q_count)) < QUEUE_DEPTH)
                       && (32'(outstanding) < MAX_OUTSTANDING);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses without a matching tag are ignored; killed or redirect-cycle responses are dropped.
  assign resp_take   = imem_resp_valid && (outstanding != '0);
  assign q_push      = resp_take && !tags[0].kill && !redirect_valid;
  assign q_push_data = '{pc: tags[0].pc, blk: imem_resp_data};

  assign fetch_valid = (q_count != '0);
  assign q_pop       = fetch_valid && !hold_fd;
  assign pc_addr_f   = fetch_valid ? q_head.pc  : 32'h0;
  assign instr_blk_f = fetch_valid ? q_head.blk : {CORE_WIDTH{NOP_INSTR}};

  // New tag lands behind the surviving ones after this cycle's response pops.
  assign wr_idx = IW'(outstanding - OW'(resp_take));

  // Tag tracker next state: shift on response, sticky kill on redirect, append on fire.
  always_comb begin
    tags_n = tags;
    if (resp_take) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) tags_n[i] = tags[i+1];
      tags_n[MAX_OUTSTANDING-1] = '0;
    end
    if (redirect_valid) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tags_n[i].kill = 1'b1;
    end
    if (req_fire) tags_n[wr_idx] = '{pc: fetch_pc, kill: redirect_valid};
  end

  // PC, run enable, outstanding count and tag storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tags[i] <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + OW'(req_fire) - OW'(resp_take);
      tags        <= tags_n;
      if (redirect_valid)  fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)   fetch_pc <= fetch_pc + fetch_bytes(CORE_WIDTH);
    end
  end

  // A response with nothing outstanding is a protocol violation by imem.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(imem_resp_valid && outstanding == '0))
        else $error("fetch_unit: imem response with no outstanding request");
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

endmodule
